// File: rtl/seven_seg_scan_driver_if.sv
// Load handshake and display-drive bundle for the 4-digit scan driver.
interface seven_seg_scan_driver_if;
  logic [13:0] bin_in;
  logic        load;
  logic        busy;
  logic        ovf;
  logic [1:0]  en;
  logic [3:0]  num;

  modport master (
    output bin_in,
    output load,
    input  busy,
    input  ovf,
    input  en,
    input  num
  );

  modport slave (
    input  bin_in,
    input  load,
    output busy,
    output ovf,
    output en,
    output num
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Binary-to-BCD (double-dabble) converter feeding a 4-digit multiplexed
// seven-segment scan with optional leading-zero blanking.
module seven_seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_seg_scan_driver_if.slave  bus
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [13:0] MAX_VAL = 14'd9999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t       state_q;
  logic         busy_q;
  logic         ovf_q;
  logic [3:0]   bit_cnt_q;
  logic [13:0]  bin_q;
  logic [15:0]  bcd_q;
  logic [15:0]  disp_q;
  logic [15:0]  bcd_adj;

  logic [CW-1:0] refresh_q, refresh_d;
  logic [1:0]    en_q, en_d;

  logic [3:0]   digit;
  logic         blank;
  logic         over;

  assign over = (bus.bin_in > MAX_VAL);

  // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: accept load, shift 14 times, then commit to the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bit_cnt_q <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      disp_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.load) begin
            bin_q     <= over ? MAX_VAL : bus.bin_in;
            ovf_q     <= over;
            busy_q    <= 1'b1;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
          bit_cnt_q      <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd13) begin
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          disp_q  <= bcd_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next-state of the free-running refresh divider and digit select.
  always_comb begin
    refresh_d = refresh_q + CW'(1);
    en_d      = en_q;
    if (refresh_q == CW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      en_d      = en_q + 2'd1;
    end
  end

  // Scan registers, independent of the conversion engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      en_q      <= '0;
    end else begin
      refresh_q <= refresh_d;
      en_q      <= en_d;
    end
  end

  // Select the active digit; a digit is blank when it and all higher ones are zero.
  always_comb begin
    digit = disp_q[3:0];
    blank = 1'b0;
    case (en_q)
      2'd0: begin
        digit = disp_q[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        digit = disp_q[7:4];
        blank = (disp_q[15:4] == '0);
      end
      2'd2: begin
        digit = disp_q[11:8];
        blank = (disp_q[15:8] == '0);
      end
      default: begin
        digit = disp_q[15:12];
        blank = (disp_q[15:12] == '0);
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_q;
  assign bus.en   = en_q;
  assign bus.num  = (BLANK_LZ && blank) ? 4'hF : digit;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench: DUT A (REFRESH_DIV=4, blanking) and DUT B (REFRESH_DIV=1,
// no blanking) share clock, reset and load stimulus.
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [13:0] bin_in;
  logic        load;

  int errors = 0;
  int checks = 0;
  int unsigned cyc;

  seven_seg_scan_driver_if if_a ();
  seven_seg_scan_driver_if if_b ();

  assign if_a.bin_in = bin_in;
  assign if_a.load   = load;
  assign if_b.bin_in = bin_in;
  assign if_b.load   = load;

  seven_seg_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  seven_seg_scan_driver #(.REFRESH_DIV(1), .BLANK_LZ(1'b0)) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release: drives the expected en for both DUTs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic do_load(input logic [13:0] val);
    @(negedge clk);
    bin_in = val;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic check_scan(input string name, input logic [15:0] exp_a,
                            input logic [15:0] exp_b, input int samples);
    logic [1:0] ea;
    logic [1:0] eb;
    for (int i = 0; i < samples; i++) begin
      @(negedge clk);
      ea = 2'((cyc >> 2) & 3);
      eb = 2'(cyc & 3);
      checks++;
      if (if_a.en !== ea) begin
        errors++;
        $display("FAIL %s en_a got=%0d want=%0d", name, if_a.en, ea);
      end
      checks++;
      if (if_a.num !== exp_a[4*ea +: 4]) begin
        errors++;
        $display("FAIL %s num_a en=%0d got=%h want=%h", name, ea, if_a.num, exp_a[4*ea +: 4]);
      end
      checks++;
      if (if_b.en !== eb) begin
        errors++;
        $display("FAIL %s en_b got=%0d want=%0d", name, if_b.en, eb);
      end
      checks++;
      if (if_b.num !== exp_b[4*eb +: 4]) begin
        errors++;
        $display("FAIL %s num_b en=%0d got=%h want=%h", name, eb, if_b.num, exp_b[4*eb +: 4]);
      end
    end
  endtask

  // Counts busy samples from the current negedge; display must hold prev value.
  task automatic wait_idle(input string name, input logic [15:0] prev_a,
                           input logic [15:0] prev_b, output int n);
    logic [1:0] ea;
    logic [1:0] eb;
    n = 0;
    while (if_a.busy === 1'b1 && n < 200) begin
      ea = 2'((cyc >> 2) & 3);
      eb = 2'(cyc & 3);
      checks++;
      if (if_a.num !== prev_a[4*ea +: 4] || if_b.num !== prev_b[4*eb +: 4]) begin
        errors++;
        $display("FAIL %s held_num got=%h/%h want=%h/%h", name, if_a.num, if_b.num,
                 prev_a[4*ea +: 4], prev_b[4*eb +: 4]);
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s busy_timeout got=%0d cycles want=15", name, n);
    end
  endtask

  task automatic check_busy_len(input string name, input int n);
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL %s busy_len got=%0d want=15", name, n);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    bin_in = '0;
    load   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if_a.busy !== 1'b0 || if_a.ovf !== 1'b0 || if_a.en !== 2'd0 || if_a.num !== 4'h0) begin
      errors++;
      $display("FAIL reset_state got busy=%b ovf=%b en=%0d num=%h want 0 0 0 0",
               if_a.busy, if_a.ovf, if_a.en, if_a.num);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_scan("reset_scan", 16'hFFF0, 16'h0000, 20);
  endtask

  task automatic test_convert();
    int n;
    do_load(14'd1234);
    wait_idle("convert_1234", 16'hFFF0, 16'h0000, n);
    check_busy_len("convert_1234", n);
    check_scan("scan_1234", 16'h1234, 16'h1234, 16);
  endtask

  task automatic test_blanking();
    int n;
    do_load(14'd7);
    wait_idle("load_7", 16'h1234, 16'h1234, n);
    check_busy_len("load_7", n);
    check_scan("scan_7", 16'hFFF7, 16'h0007, 16);
    do_load(14'd1005);
    wait_idle("load_1005", 16'hFFF7, 16'h0007, n);
    check_scan("scan_1005", 16'h1005, 16'h1005, 16);
  endtask

  task automatic test_clamp();
    int n;
    do_load(14'd12000);
    checks++;
    if (if_a.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got=%b want=1", if_a.ovf);
    end
    wait_idle("load_12000", 16'h1005, 16'h1005, n);
    check_busy_len("load_12000", n);
    check_scan("scan_clamp", 16'h9999, 16'h9999, 16);
    do_load(14'd42);
    checks++;
    if (if_a.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got=%b want=0", if_a.ovf);
    end
    wait_idle("load_42", 16'h9999, 16'h9999, n);
    check_scan("scan_42", 16'hFF42, 16'h0042, 16);
  endtask

  task automatic test_back_to_back();
    int n;
    do_load(14'd4321);
    repeat (4) @(negedge clk);
    bin_in = 14'd1111;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    wait_idle("load_4321", 16'hFF42, 16'h0042, n);
    check_busy_len("ignored_load", n + 5);
    check_scan("scan_4321", 16'h4321, 16'h4321, 16);
  endtask

  task automatic test_reset_mid();
    do_load(14'd9999);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if_a.busy !== 1'b0 || if_a.en !== 2'd0 || if_a.num !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b en=%0d num=%h want 0 0 0", if_a.busy, if_a.en, if_a.num);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_scan("scan_after_reset", 16'hFFF0, 16'h0000, 20);
    checks++;
    if (if_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_reset got=%b want=0", if_a.busy);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_blanking();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
